debug_reg_writer: RTL and testbench

- Board-side writer for the processor's debug register port: the complement of the register read-out path that drives the 7-segment displays.
- The user builds a hex word one nibble at a time from switches and key presses, selects a target register, and commits.
- The block issues a req/ack write transaction into the core's register file.
- It exposes the low byte of the word being entered for the HexTo7Seg digits, plus busy, done and error status.

---
 rtl/debug_writer_pkg.sv | 21 ++
 rtl/key_edge_detect.sv | 19 +
 rtl/debug_reg_writer.sv | 116 +++++++++++
 tb/tb_debug_reg_writer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_writer_pkg.sv
// Shared types and constants for the debug register writer: FSM states,
// the nibble-slot helper and the read-only x0 register address.
package debug_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    REQ   = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_W = 32;
  localparam int NIBBLES        = DEFAULT_DATA_W / 4;

  // Register x0 is hardwired to zero in the core, so writes to it are refused.
  localparam int X0_ADDR = 0;

  function automatic int nibble_slots(input int data_w);
    return data_w / 4;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a debounced key level. The previous sample resets
// high so a key held through reset must be released before it can fire.
module key_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_rise
);

  logic prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_reg <= 1'b1;
    else       prev_reg <= key;
  end

  assign key_rise = key & ~prev_reg;

endmodule

// File: rtl/debug_reg_writer.sv
// Builds a hex word from switch nibbles and key presses, then writes it into
// the core's register file over a req/ack port with a bounded wait.
module debug_reg_writer
  import debug_writer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        sw_nibble,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic              key_load,
  input  logic              key_commit,
  input  logic              key_cancel,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic [7:0]        entry_preview,
  output logic [3:0]        nibble_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int          NIB      = nibble_slots(DATA_W);
  localparam logic [3:0]  NIB_MAX  = 4'(NIB);
  localparam int          TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_X0 = ADDR_W'(X0_ADDR);

  state_e            state_reg;
  logic [DATA_W-1:0] entry_reg;
  logic [3:0]        count_reg;
  logic [TW-1:0]     tmo_reg;
  logic              load_rise, commit_rise, cancel_rise;
  logic [DATA_W-1:0] entry_shifted;

  key_edge_detect u_load_edge (
    .clk(clk), .reset(reset), .key(key_load), .key_rise(load_rise)
  );
  key_edge_detect u_commit_edge (
    .clk(clk), .reset(reset), .key(key_commit), .key_rise(commit_rise)
  );
  key_edge_detect u_cancel_edge (
    .clk(clk), .reset(reset), .key(key_cancel), .key_rise(cancel_rise)
  );

  assign entry_shifted = {entry_reg[DATA_W-5:0], sw_nibble};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      entry_reg <= '0;
      count_reg <= '0;
      tmo_reg   <= '0;
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        IDLE, ENTER: begin
          // cancel > commit > load; lower-priority edges in the same cycle are dropped
          if (cancel_rise) begin
            entry_reg <= '0;
            count_reg <= '0;
            state_reg <= IDLE;
          end else if (commit_rise) begin
            if (sw_addr == ADDR_X0) begin
              err <= 1'b1;
            end else begin
              wr_addr   <= sw_addr;
              wr_data   <= entry_reg;
              wr_req    <= 1'b1;
              tmo_reg   <= '0;
              state_reg <= REQ;
            end
          end else if (load_rise) begin
            entry_reg <= entry_shifted;
            if (state_reg == IDLE)        count_reg <= 4'd1;
            else if (count_reg < NIB_MAX) count_reg <= count_reg + 4'd1;
            state_reg <= ENTER;
          end
        end
        REQ: begin
          if (wr_ack) begin
            wr_req    <= 1'b0;
            done      <= 1'b1;
            entry_reg <= '0;
            count_reg <= '0;
            state_reg <= IDLE;
          end else if (tmo_reg == TMO_LAST) begin
            // Abandon the write but keep the entry so the user can retry
            wr_req    <= 1'b0;
            err       <= 1'b1;
            state_reg <= (count_reg == 4'd0) ? IDLE : ENTER;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy          = (state_reg == REQ);
  assign entry_preview = entry_reg[7:0];
  assign nibble_count  = count_reg;

endmodule

// File: tb/tb_debug_reg_writer.sv
// Directed bench for debug_reg_writer: stimulus queues expected write/done/err
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_debug_reg_writer;

  localparam int K_START = 0, K_END = 1, K_DONE = 2, K_ERR = 3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [7:0]  len;
    logic [7:0]  prev;
    logic [3:0]  cnt;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sw_nibble = 4'h0;
  logic [4:0]  sw_addr = 5'd0;
  logic        key_load = 1'b0, key_commit = 1'b0, key_cancel = 1'b0;
  logic        wr_req, wr_ack = 1'b0;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  entry_preview;
  logic [3:0]  nibble_count;
  logic        busy, done, err;

  int   checks = 0;
  int   passes = 0;
  ev_t  exp_q[$];

  debug_reg_writer #(.DATA_W(32), .ADDR_W(5), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .sw_nibble(sw_nibble), .sw_addr(sw_addr),
    .key_load(key_load), .key_commit(key_commit), .key_cancel(key_cancel),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .entry_preview(entry_preview), .nibble_count(nibble_count),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic ev_t mk(input int kind, input logic [4:0] a, input logic [31:0] d,
                             input int len, input logic [7:0] pv, input logic [3:0] c);
    ev_t e;
    e.kind = 2'(kind); e.addr = a; e.data = d; e.len = 8'(len); e.prev = pv; e.cnt = c;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic observe(input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h len=%0d prev=%0h cnt=%0d, expected none",
               got.kind, got.addr, got.data, got.len, got.prev, got.cnt);
    end else begin
      e = exp_q.pop_front();
      if (got == e) begin
        passes++;
        $display("event kind=%0d addr=%0h data=%0h len=%0d prev=%0h cnt=%0d ok",
                 got.kind, got.addr, got.data, got.len, got.prev, got.cnt);
      end else begin
        $display("FAIL event: got kind=%0d addr=%0h data=%0h len=%0d prev=%0h cnt=%0d, expected kind=%0d addr=%0h data=%0h len=%0d prev=%0h cnt=%0d",
                 got.kind, got.addr, got.data, got.len, got.prev, got.cnt,
                 e.kind, e.addr, e.data, e.len, e.prev, e.cnt);
      end
    end
  endtask

  // Monitor: converts DUT output activity into events
  initial begin
    logic        req_prev;
    int          req_len;
    logic [4:0]  hold_addr;
    logic [31:0] hold_data;
    req_prev = 1'b0; req_len = 0; hold_addr = '0; hold_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        req_prev = 1'b0; req_len = 0;
      end else begin
        if (wr_req) req_len++;
        if (wr_req && !req_prev) begin
          hold_addr = wr_addr; hold_data = wr_data;
          observe(mk(K_START, wr_addr, wr_data, 0, 8'h00, 4'd0));
        end
        if (wr_req && req_prev) begin
          checks++;
          if (wr_addr === hold_addr && wr_data === hold_data) passes++;
          else $display("FAIL req_stable: got %0h/%0h, expected %0h/%0h",
                        wr_addr, wr_data, hold_addr, hold_data);
        end
        if (!wr_req && req_prev) begin
          observe(mk(K_END, 5'd0, 32'd0, req_len, 8'h00, 4'd0));
          req_len = 0;
        end
        if (done) observe(mk(K_DONE, 5'd0, 32'd0, 0, entry_preview, nibble_count));
        if (err)  observe(mk(K_ERR, 5'd0, 32'd0, 0, entry_preview, nibble_count));
        req_prev = wr_req;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_load(input logic [3:0] n);
    sw_nibble = n; key_load = 1'b1; tick();
    key_load = 1'b0; tick();
  endtask

  task automatic press_cancel();
    key_cancel = 1'b1; tick();
    key_cancel = 1'b0; tick();
  endtask

  // Commit (optionally with a simultaneous load) and ack after ack_delay cycles
  task automatic commit_ack(input logic [4:0] a, input logic with_load, input int ack_delay);
    sw_addr = a; key_commit = 1'b1; key_load = with_load; tick();
    key_commit = 1'b0; key_load = 1'b0;
    repeat (ack_delay - 1) tick();
    wr_ack = 1'b1; tick();
    wr_ack = 1'b0; tick(); tick();
  endtask

  initial begin
    // Key held through reset must not fire
    key_load = 1'b1; sw_nibble = 4'h5;
    repeat (3) tick();
    check("reset_wr_req", 32'(wr_req), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(); tick();
    check("held_key_preview", 32'(entry_preview), 32'h00);
    check("held_key_count", 32'(nibble_count), 32'd0);
    key_load = 1'b0; tick();
    key_load = 1'b1; tick();
    check("repress_preview", 32'(entry_preview), 32'h05);
    check("repress_count", 32'(nibble_count), 32'd1);
    key_load = 1'b0; tick();
    press_cancel();
    check("cancel_count", 32'(nibble_count), 32'd0);

    // A,B,C,D to register 5, ack after 3 cycles
    press_load(4'hA); press_load(4'hB); press_load(4'hC); press_load(4'hD);
    check("abcd_preview", 32'(entry_preview), 32'hCD);
    check("abcd_count", 32'(nibble_count), 32'd4);
    exp_q.push_back(mk(K_START, 5'd5, 32'h0000ABCD, 0, 8'h00, 4'd0));
    exp_q.push_back(mk(K_END, 5'd0, 32'd0, 3, 8'h00, 4'd0));
    exp_q.push_back(mk(K_DONE, 5'd0, 32'd0, 0, 8'h00, 4'd0));
    commit_ack(5'd5, 1'b0, 3);

    // Nine nibbles: count saturates, oldest nibble falls out
    for (int i = 1; i <= 9; i++) press_load(4'(i));
    check("nine_count", 32'(nibble_count), 32'd8);
    check("nine_preview", 32'(entry_preview), 32'h89);
    exp_q.push_back(mk(K_START, 5'd9, 32'h23456789, 0, 8'h00, 4'd0));
    exp_q.push_back(mk(K_END, 5'd0, 32'd0, 2, 8'h00, 4'd0));
    exp_q.push_back(mk(K_DONE, 5'd0, 32'd0, 0, 8'h00, 4'd0));
    commit_ack(5'd9, 1'b0, 2);

    // Commit to x0 refused with an err pulse, entry kept
    press_load(4'h5);
    exp_q.push_back(mk(K_ERR, 5'd0, 32'd0, 0, 8'h05, 4'd1));
    sw_addr = 5'd0; key_commit = 1'b1; tick();
    key_commit = 1'b0; repeat (3) tick();
    check("x0_preview", 32'(entry_preview), 32'h05);
    check("x0_busy", 32'(busy), 32'd0);

    // Timeout: no ack, load pressed during REQ must be ignored
    press_cancel();
    press_load(4'hE); press_load(4'hF); press_load(4'h1);
    check("tmo_pre_preview", 32'(entry_preview), 32'hF1);
    exp_q.push_back(mk(K_START, 5'd3, 32'h00000EF1, 0, 8'h00, 4'd0));
    exp_q.push_back(mk(K_END, 5'd0, 32'd0, 8, 8'h00, 4'd0));
    exp_q.push_back(mk(K_ERR, 5'd0, 32'd0, 0, 8'hF1, 4'd3));
    sw_addr = 5'd3; key_commit = 1'b1; tick();
    key_commit = 1'b0; tick();
    check("tmo_busy", 32'(busy), 32'd1);
    sw_nibble = 4'h7; key_load = 1'b1; tick();
    key_load = 1'b0;
    repeat (10) tick();
    check("tmo_after_busy", 32'(busy), 32'd0);
    check("tmo_after_count", 32'(nibble_count), 32'd3);
    press_load(4'h2);
    check("tmo_enter_count", 32'(nibble_count), 32'd4);
    check("tmo_enter_preview", 32'(entry_preview), 32'h12);
    press_cancel();
    check("tmo_cancel_count", 32'(nibble_count), 32'd0);
    check("tmo_cancel_preview", 32'(entry_preview), 32'h00);

    // Cancel beats commit and load in the same cycle
    press_load(4'h3); press_load(4'h4);
    sw_addr = 5'd7; sw_nibble = 4'hC;
    key_cancel = 1'b1; key_commit = 1'b1; key_load = 1'b1; tick();
    key_cancel = 1'b0; key_commit = 1'b0; key_load = 1'b0; tick(); tick();
    check("tri_count", 32'(nibble_count), 32'd0);
    check("tri_preview", 32'(entry_preview), 32'h00);
    check("tri_busy", 32'(busy), 32'd0);

    // Commit beats load: request carries pre-shift data
    press_load(4'h6); press_load(4'h8);
    sw_nibble = 4'h9;
    exp_q.push_back(mk(K_START, 5'd7, 32'h00000068, 0, 8'h00, 4'd0));
    exp_q.push_back(mk(K_END, 5'd0, 32'd0, 1, 8'h00, 4'd0));
    exp_q.push_back(mk(K_DONE, 5'd0, 32'd0, 0, 8'h00, 4'd0));
    commit_ack(5'd7, 1'b1, 1);
    check("cl_preview", 32'(entry_preview), 32'h00);

    repeat (4) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
